mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Moore FSM sequencing a shift-add multiplier datapath: load, test b, add a into p, shift, done.
// Optional MULT_SEQ_CTRL_MERGE_EN folds the shift into the ADD state, saving one cycle per set multiplier bit.
module mult_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic zero,
  input  logic lsb_b,
  output logic en_a,
  output logic ld_shift_a,
  output logic en_b,
  output logic ld_shift_b,
  output logic en_p,
  output logic ld_add_p,
  output logic busy,
  output logic done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(WIDTH);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] iter_inc;

  // Saturate at WIDTH so the counter can never wrap back below the cap.
  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        if (zero)                    state_d = S_DONE;
        else if (iter_q == ITER_MAX) state_d = S_DONE;
        else if (lsb_b)              state_d = S_ADD;
        else                         state_d = S_SHIFT;
      end
      S_ADD: begin
`ifdef MULT_SEQ_CTRL_MERGE_EN
        iter_d  = iter_inc;
        state_d = S_TEST;
`else
        state_d = S_SHIFT;
`endif
      end
      S_SHIFT: begin
        iter_d  = iter_inc;
        state_d = S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Outputs depend on state_q alone; every asserted enable comes with its select.
  always_comb begin
    en_a       = 1'b0;
    ld_shift_a = 1'b0;
    en_b       = 1'b0;
    ld_shift_b = 1'b0;
    en_p       = 1'b0;
    ld_add_p   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        en_a = 1'b1;
        en_b = 1'b1;
        en_p = 1'b1;
        busy = 1'b1;
      end
      S_TEST: begin
        busy = 1'b1;
      end
      S_ADD: begin
        en_p     = 1'b1;
        ld_add_p = 1'b1;
        busy     = 1'b1;
`ifdef MULT_SEQ_CTRL_MERGE_EN
        // p + a captures the pre-shift a on the same edge that shifts a.
        en_a       = 1'b1;
        ld_shift_a = 1'b1;
        en_b       = 1'b1;
        ld_shift_b = 1'b1;
`endif
      end
      S_SHIFT: begin
        en_a       = 1'b1;
        ld_shift_a = 1'b1;
        en_b       = 1'b1;
        ld_shift_b = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a small shift-add datapath model providing zero/lsb_b and p_out.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  logic clr, start, zero, lsb_b;
  logic en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done;

  logic [3:0] a_in, b_in, b_q;
  logic [7:0] a_q, p_q;
  logic       force_nz;
  logic [2:0] code;
  logic [23:0] trace;
  logic       saw_sa;
  logic       prev_done;
  int checks, errors;

`ifdef MULT_SEQ_CTRL_MERGE_EN
  localparam int L32 = 7, L50 = 3, L1515 = 11, L79 = 11, L43 = 7, LCAP = 11;
  localparam logic [23:0] TRACE32 = {3'd0, 3'd1, 3'd2, 3'd4, 3'd2, 3'd3, 3'd2, 3'd5};
`else
  localparam int L32 = 8, L50 = 3, L1515 = 15, L79 = 13, L43 = 9, LCAP = 12;
  localparam logic [23:0] TRACE32 = {3'd1, 3'd2, 3'd4, 3'd2, 3'd3, 3'd4, 3'd2, 3'd5};
`endif

  mult_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .start(start), .zero(zero), .lsb_b(lsb_b),
    .en_a(en_a), .ld_shift_a(ld_shift_a), .en_b(en_b), .ld_shift_b(ld_shift_b),
    .en_p(en_p), .ld_add_p(ld_add_p), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (en_a) a_q <= ld_shift_a ? {a_q[6:0], 1'b0} : {4'b0000, a_in};
    if (en_b) b_q <= ld_shift_b ? {1'b0, b_q[3:1]} : b_in;
    if (en_p) p_q <= ld_add_p ? p_q + a_q : 8'd0;
  end

  assign zero  = force_nz ? 1'b0 : (b_q == 4'd0);
  assign lsb_b = b_q[0];

  // Classify the visible state from the outputs: 0 IDLE,1 LOAD,2 TEST,3 ADD,4 SHIFT,5 DONE.
  always_comb begin
    code = 3'd2;
    if (done)                     code = 3'd5;
    else if (!busy)               code = 3'd0;
    else if (en_p && ld_add_p)    code = 3'd3;
    else if (en_a && !ld_shift_a) code = 3'd1;
    else if (en_a)                code = 3'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!busy) chk("idle_no_enables", 32'({en_a, en_b, en_p}), 32'd0);
    chk("busy_and_done", 32'(busy && done), 32'd0);
    chk("done_twice", 32'(prev_done && done), 32'd0);
    prev_done = done;
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                        input logic [7:0] exp_p, input int pulse_at, input string tag);
    int cyc;
    bit got;
    @(posedge clk); #1;
    a_in = a; b_in = b; start = 1'b1;
    trace = '0; saw_sa = 1'b0; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      trace = {trace[20:0], code};
      if ((en_p && ld_add_p) || (en_a && ld_shift_a) || (en_b && ld_shift_b)) saw_sa = 1'b1;
      if (done) got = 1'b1;
      start = (cyc == pulse_at);
    end
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_p_out"}, 32'(p_q), 32'(exp_p));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_idle_after"}, 32'(code), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_not_queued"}, 32'(code), 32'd0);
  endtask

  initial begin
    int cyc;
    bit got;
    checks = 0; errors = 0; prev_done = 1'b0;
    clr = 1'b1; start = 1'b0; force_nz = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done}), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("reset_idle", 32'(code), 32'd0);

    // 3x2 with a stray start pulse mid-operation
    run_op(4'd3, 4'd2, L32, 8'd6, 4, "m3x2");
    chk("m3x2_trace", 32'(trace), 32'(TRACE32));

    run_op(4'd5, 4'd0, L50, 8'd0, 0, "m5x0");
    chk("m5x0_no_add_shift", 32'(saw_sa), 32'd0);

    // start pulsed in the DONE cycle must be dropped
    run_op(4'd15, 4'd15, L1515, 8'd225, L1515, "m15x15");

    // Iteration cap: zero masked off, the counter must end the operation at WIDTH
    force_nz = 1'b1;
    run_op(4'd5, 4'd1, LCAP, 8'd5, 0, "cap");
    force_nz = 1'b0;

    // Abort with clr while in ADD
    @(posedge clk); #1;
    a_in = 4'd7; b_in = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_add", 32'(code), 32'd3);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("abort_outputs", 32'({en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done}), 32'd0);
    run_op(4'd7, 4'd9, L79, 8'd63, 0, "m7x9");

    // start held high: back-to-back 3x2 then 4x3
    @(posedge clk); #1;
    a_in = 4'd3; b_in = 4'd2; start = 1'b1; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk("b2b1_timeout", 32'(got), 32'd1);
    chk("b2b1_latency", 32'(cyc), 32'(L32));
    chk("b2b1_p_out", 32'(p_q), 32'd6);
    a_in = 4'd4; b_in = 4'd3;
    @(posedge clk); #1;
    chk("b2b_gap_idle", 32'(code), 32'd0);
    @(posedge clk); #1;
    chk("b2b_second_load", 32'(code), 32'd1);
    cyc = 1; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("b2b2_timeout", 32'(got), 32'd1);
    chk("b2b2_latency", 32'(cyc), 32'(L43));
    chk("b2b2_p_out", 32'(p_q), 32'd12);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
